// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative 32-bit shift-add multiply / restoring divide unit
//               that owns the HI/LO registers and raises the HI/LO stall.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mul_start,
    input  logic        div_start,
    input  logic        signed_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_lo_write_en,
    input  logic        hi_lo_reg_control,
    input  logic [31:0] mt_data,
    input  logic        read_req,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        divide_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_dz;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_top;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_res_neg;

    assign w_abs_a   = (signed_op & op_a[31]) ? (~op_a + 32'd1) : op_a;
    assign w_abs_b   = (signed_op & op_b[31]) ? (~op_b + 32'd1) : op_b;
    assign w_res_neg = signed_op & (op_a[31] ^ op_b[31]);

    // Multiply: multiplier sits in the low half and is shifted out LSB first.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: the shifted partial remainder can reach 33 bits, so compare at that width.
    assign w_div_top  = r_acc[63:31];
    assign w_div_diff = w_div_top - {1'b0, r_opnd};
    assign w_div_next = w_div_diff[32] ? {r_acc[62:0], 1'b0}
                                       : {w_div_diff[31:0], r_acc[30:0], 1'b1};

    assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= 64'd0;
            r_opnd    <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= 5'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (hi_lo_write_en) begin
                            if (hi_lo_reg_control) r_hi <= mt_data;
                            else                   r_lo <= mt_data;
                        end
                        if (mul_start) begin
                            r_is_div  <= 1'b0;
                            r_neg_res <= w_res_neg;
                            r_neg_rem <= 1'b0;
                            r_acc     <= {32'd0, w_abs_b};
                            r_opnd    <= w_abs_a;
                            r_cnt     <= 5'd0;
                            r_busy    <= 1'b1;
                            r_state   <= S_RUN;
                        end else if (div_start) begin
                            if (op_b == 32'd0) begin
                                r_dz <= 1'b1;
                            end else begin
                                r_is_div  <= 1'b1;
                                r_neg_res <= w_res_neg;
                                r_neg_rem <= signed_op & op_a[31];
                                r_acc     <= {32'd0, w_abs_a};
                                r_opnd    <= w_abs_b;
                                r_cnt     <= 5'd0;
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) r_state <= S_FIXUP;
                    end
                    S_FIXUP: begin
                        if (r_is_div) begin
                            r_lo <= w_quo;
                            r_hi <= w_rem;
                        end else begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign divide_zero = r_dz;
    assign stall       = r_busy & (read_req | hi_lo_write_en | mul_start | div_start);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Randomized self-checking bench for muldiv_sequencer against an
//               arithmetic reference model of HI/LO results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_start, div_start, signed_op;
    logic [31:0] op_a, op_b;
    logic        hi_lo_write_en, hi_lo_reg_control;
    logic [31:0] mt_data;
    logic        read_req, flush;
    logic [31:0] hi, lo;
    logic        busy, stall, done, divide_zero;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_sequencer u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mul_start         (mul_start),
        .div_start         (div_start),
        .signed_op         (signed_op),
        .op_a              (op_a),
        .op_b              (op_b),
        .hi_lo_write_en    (hi_lo_write_en),
        .hi_lo_reg_control (hi_lo_reg_control),
        .mt_data           (mt_data),
        .read_req          (read_req),
        .flush             (flush),
        .hi                (hi),
        .lo                (lo),
        .busy              (busy),
        .stall             (stall),
        .done              (done),
        .divide_zero       (divide_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic logic [63:0] ref_result(input bit is_div, input bit sgn,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (!is_div) return sa * sb;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt_write(input bit sel_hi, input logic [31:0] data);
        hi_lo_write_en = 1'b1; hi_lo_reg_control = sel_hi; mt_data = data;
        tick();
        hi_lo_write_en = 1'b0;
        if (sel_hi) m_hi = data; else m_lo = data;
        check_val("mt_hi", hi, m_hi);
        check_val("mt_lo", lo, m_lo);
    endtask

    task automatic do_op(input bit is_div, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input int rr_at);
        logic [63:0] expv;
        int cyc, bcnt, stall_miss;
        mul_start = !is_div; div_start = is_div; signed_op = sgn; op_a = a; op_b = b;
        tick();
        mul_start = 1'b0; div_start = 1'b0; op_a = $urandom; op_b = $urandom;
        if (is_div && b == 32'd0) begin
            check_val("dz_pulse", divide_zero, 1);
            check_val("dz_busy", busy, 0);
            check_val("dz_hi", hi, m_hi);
            check_val("dz_lo", lo, m_lo);
            tick();
            check_val("dz_clear", divide_zero, 0);
            check_val("dz_nodone", done, 0);
            return;
        end
        expv = ref_result(is_div, sgn, a, b);
        cyc = 0; bcnt = 0; stall_miss = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            if (rr_at >= 0 && cyc == rr_at) read_req = 1'b1;
            tick();
            cyc++;
            if (read_req && !done && !stall) stall_miss++;
        end
        check_val("latency", cyc, 33);
        check_val("busy_cycles", bcnt, 33);
        check_val(is_div ? "div_hi" : "mul_hi", hi, expv[63:32]);
        check_val(is_div ? "div_lo" : "mul_lo", lo, expv[31:0]);
        if (rr_at >= 0) begin
            check_val("stall_held", stall_miss, 0);
            check_val("stall_done", stall, 0);
            read_req = 1'b0;
        end
        m_hi = expv[63:32];
        m_lo = expv[31:0];
    endtask

    task automatic flush_div(input logic [31:0] a, input logic [31:0] b);
        int dn;
        div_start = 1'b1; signed_op = 1'b0; op_a = a; op_b = b;
        tick();
        div_start = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush_busy", busy, 0);
        dn = 0;
        repeat (40) begin
            if (done) dn++;
            tick();
        end
        check_val("flush_nodone", dn, 0);
        check_val("flush_hi", hi, m_hi);
        check_val("flush_lo", lo, m_lo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; mul_start = 1'b0; div_start = 1'b0; signed_op = 1'b0;
        op_a = 32'd0; op_b = 32'd0; hi_lo_write_en = 1'b0; hi_lo_reg_control = 1'b0;
        mt_data = 32'd0; read_req = 1'b0; flush = 1'b0;
        repeat (2) tick();
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;

        // Load nonzero HI/LO, then reset in the middle of a multiply.
        mt_write(1'b1, 32'hDEAD_BEEF);
        mt_write(1'b0, 32'hCAFE_F00D);
        mul_start = 1'b1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        tick();
        mul_start = 1'b0;
        repeat (10) tick();
        check_val("mid_busy", busy, 1);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        check_val("midrst_hi", hi, 0);
        check_val("midrst_lo", lo, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);

        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check_val("ffxff_hi", hi, 32'hFFFF_FFFE);
        check_val("ffxff_lo", lo, 32'h0000_0001);
        tick();
        check_val("done_pulse", done, 0);
        do_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, -1);
        check_val("m3x5_lo", lo, 32'hFFFF_FFF1);
        do_op(1'b0, 1'b0, 32'h8000_0000, 32'd2, -1);
        do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        check_val("m7d2_lo", lo, 32'hFFFF_FFFD);
        check_val("m7d2_hi", hi, 32'hFFFF_FFFF);
        do_op(1'b1, 1'b0, 32'd7, 32'd2, -1);
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check_val("ovf_lo", lo, 32'h8000_0000);
        check_val("ovf_hi", hi, 32'h0);

        mt_write(1'b1, 32'h11);
        mt_write(1'b0, 32'h22);
        do_op(1'b1, 1'b1, 32'd5, 32'd0, -1);

        do_op(1'b0, 1'b1, $urandom, $urandom, 5);
        flush_div(32'd1000, 32'd7);
        mt_write(1'b1, 32'h0000_1234);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            if (($urandom % 8) == 0) a = 32'h8000_0000;
            case ($urandom % 8)
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom % 16;
                default: b = $urandom;
            endcase
            do_op(1'($urandom % 2), 1'($urandom % 2), a, b, -1);
            if (($urandom % 2) == 0) begin
                tick();
                check_val("idle_done", done, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
